// File: rtl/hssi_rst_ack_responder.sv
// Responder for the HSSI CSR cold/TX/RX reset request-acknowledge handshake:
// holds channel resets for at least HOLD_CYC, then acks until the channel reports ready or times out.
module hssi_rst_dir #(
  parameter int HOLD_CYC    = 16,
  parameter int TIMEOUT_CYC = 100000,
  parameter int CW          = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic own,
  input  logic own_rst,
  input  logic req,
  input  logic ready,
  output logic chan_rst,
  output logic ack,
  output logic to_hit
);
  typedef enum logic [1:0] {IDLE, ASSERT, HELD, RELEASE} st_t;

  localparam logic [CW-1:0] HOLD_V  = CW'(HOLD_CYC);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  st_t           st;
  logic [CW-1:0] cnt;
  logic          short_q;

  assign to_hit = !own && (st == RELEASE) && !ready && (cnt >= TO_LAST);

  // own: the cold sequencer has taken every channel; its reset level wins and no error is raised
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      cnt      <= '0;
      short_q  <= 1'b0;
      chan_rst <= 1'b1;
      ack      <= 1'b0;
    end else if (own) begin
      st       <= IDLE;
      cnt      <= '0;
      short_q  <= 1'b0;
      chan_rst <= own_rst;
      ack      <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (req) begin
            st       <= ASSERT;
            chan_rst <= 1'b1;
            cnt      <= CW'(1);
          end
        end
        ASSERT: begin
          if (cnt >= HOLD_V) begin
            st      <= HELD;
            ack     <= 1'b1;
            short_q <= !req;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HELD: begin
          // a request dropped before the hold finished gets a single-cycle ack
          if (short_q || !req) begin
            st       <= RELEASE;
            chan_rst <= 1'b0;
            ack      <= !short_q;
            cnt      <= '0;
          end
        end
        RELEASE: begin
          if (ready || (cnt >= TO_LAST)) begin
            st  <= IDLE;
            ack <= 1'b0;
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

module hssi_rst_ack_responder #(
  parameter int NUM_CH      = 16,
  parameter int HOLD_CYC    = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cold_rst,
  output logic              o_cold_rst_ack,
  input  logic [NUM_CH-1:0] i_tx_rst,
  input  logic [NUM_CH-1:0] i_rx_rst,
  output logic [NUM_CH-1:0] o_tx_rst_ack,
  output logic [NUM_CH-1:0] o_rx_rst_ack,
  output logic [NUM_CH-1:0] o_chan_tx_rst,
  output logic [NUM_CH-1:0] o_chan_rx_rst,
  input  logic [NUM_CH-1:0] i_tx_lanes_stable,
  input  logic [NUM_CH-1:0] i_rx_pcs_ready,
  output logic [NUM_CH-1:0] o_timeout_err
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] HOLD_V  = CW'(HOLD_CYC);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {C_INIT, C_IDLE, C_ASSERT, C_HELD, C_RELEASE} cst_t;

  cst_t              cst;
  logic [CW-1:0]     ccnt;
  logic [NUM_CH-1:0] ch_ready;
  logic              all_ready;
  logic              own;
  logic              own_rst;
  logic [NUM_CH-1:0] tx_to;
  logic [NUM_CH-1:0] rx_to;

  assign ch_ready  = i_tx_lanes_stable & i_rx_pcs_ready;
  assign all_ready = &ch_ready;

  // next-cycle channel reset level whenever the cold sequencer owns the channels
  always_comb begin
    own     = 1'b1;
    own_rst = 1'b0;
    case (cst)
      C_IDLE: begin
        own     = i_cold_rst;
        own_rst = i_cold_rst;
      end
      C_ASSERT: own_rst = 1'b1;
      C_HELD:   own_rst = i_cold_rst;
      default:  own_rst = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cst            <= C_INIT;
      ccnt           <= '0;
      o_cold_rst_ack <= 1'b0;
      o_timeout_err  <= '0;
    end else begin
      o_timeout_err <= o_timeout_err | tx_to | rx_to;
      case (cst)
        C_INIT: begin
          if (all_ready || (ccnt >= TO_LAST)) begin
            cst  <= C_IDLE;
            ccnt <= '0;
          end else begin
            ccnt <= ccnt + CW'(1);
          end
        end
        C_IDLE: begin
          if (i_cold_rst) begin
            cst           <= C_ASSERT;
            ccnt          <= CW'(1);
            o_timeout_err <= '0;
          end
        end
        C_ASSERT: begin
          if (ccnt >= HOLD_V) begin
            cst            <= C_HELD;
            o_cold_rst_ack <= 1'b1;
          end else begin
            ccnt <= ccnt + CW'(1);
          end
        end
        C_HELD: begin
          if (!i_cold_rst) begin
            cst  <= C_RELEASE;
            ccnt <= '0;
          end
        end
        C_RELEASE: begin
          if (all_ready) begin
            cst            <= C_IDLE;
            o_cold_rst_ack <= 1'b0;
          end else if (ccnt >= TO_LAST) begin
            cst            <= C_IDLE;
            o_cold_rst_ack <= 1'b0;
            o_timeout_err  <= o_timeout_err | ~ch_ready;
          end else begin
            ccnt <= ccnt + CW'(1);
          end
        end
        default: cst <= C_INIT;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    hssi_rst_dir #(.HOLD_CYC(HOLD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .CW(CW)) u_tx (
      .clk(clk), .rst(rst), .own(own), .own_rst(own_rst),
      .req(i_tx_rst[g]), .ready(i_tx_lanes_stable[g]),
      .chan_rst(o_chan_tx_rst[g]), .ack(o_tx_rst_ack[g]), .to_hit(tx_to[g])
    );
    hssi_rst_dir #(.HOLD_CYC(HOLD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .CW(CW)) u_rx (
      .clk(clk), .rst(rst), .own(own), .own_rst(own_rst),
      .req(i_rx_rst[g]), .ready(i_rx_pcs_ready[g]),
      .chan_rst(o_chan_rx_rst[g]), .ack(o_rx_rst_ack[g]), .to_hit(rx_to[g])
    );
  end
endmodule

// File: tb/tb_hssi_rst_ack_responder.sv
// Bench for hssi_rst_ack_responder: closed-form timing expectations per handshake,
// directed power-up / cold / async-reset cases plus randomized channel transactions.
module tb_hssi_rst_ack_responder;
  localparam int NUM_CH = 16;
  localparam int HOLD_CYC = 16;
  localparam int TIMEOUT_CYC = 64;
  localparam logic [NUM_CH-1:0] ALL = '1;

  logic              clk;
  logic              rst;
  logic              cold_rst;
  logic              cold_ack;
  logic [NUM_CH-1:0] tx_rst, rx_rst, tx_ack, rx_ack;
  logic [NUM_CH-1:0] chan_tx_rst, chan_rx_rst;
  logic [NUM_CH-1:0] tx_stable, rx_ready, to_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [NUM_CH-1:0] err_prev;

  hssi_rst_ack_responder #(.NUM_CH(NUM_CH), .HOLD_CYC(HOLD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst),
    .i_cold_rst(cold_rst), .o_cold_rst_ack(cold_ack),
    .i_tx_rst(tx_rst), .i_rx_rst(rx_rst),
    .o_tx_rst_ack(tx_ack), .o_rx_rst_ack(rx_ack),
    .o_chan_tx_rst(chan_tx_rst), .o_chan_rx_rst(chan_rx_rst),
    .i_tx_lanes_stable(tx_stable), .i_rx_pcs_ready(rx_ready),
    .o_timeout_err(to_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // One request on one channel/direction; every output is predicted from closed-form event times.
  task automatic run_dir(input bit rx, input int ch, input int len, input int dly);
    int n, hs, m, r, e;
    bit shrt, to;
    logic [NUM_CH-1:0] bitv, rst_e, ack_e, err_e;
    n = cyc;
    hs = n + 1 + HOLD_CYC;
    shrt = (len <= HOLD_CYC);
    m = shrt ? hs : n + len;
    r = m + 1;
    to = (dly >= TIMEOUT_CYC);
    e = r + ((dly < TIMEOUT_CYC) ? dly : TIMEOUT_CYC - 1) + 1;
    bitv = '0;
    bitv[ch] = 1'b1;
    err_e = err_prev;
    for (int c = n; c <= e + 2; c++) begin
      if (rx) begin
        rx_rst   = (c < n + len) ? bitv : '0;
        rx_ready = (c >= r + dly) ? ALL : ~bitv;
      end else begin
        tx_rst    = (c < n + len) ? bitv : '0;
        tx_stable = (c >= r + dly) ? ALL : ~bitv;
      end
      sample();
      rst_e = (c > n && c <= m) ? bitv : '0;
      if (shrt) ack_e = (c == hs) ? bitv : '0;
      else      ack_e = (c >= hs && c < e) ? bitv : '0;
      err_e = err_prev | ((to && c >= r + TIMEOUT_CYC) ? bitv : '0);
      chk("chan_tx_rst", chan_tx_rst, rx ? '0 : rst_e);
      chk("chan_rx_rst", chan_rx_rst, rx ? rst_e : '0);
      chk("tx_ack", tx_ack, rx ? '0 : ack_e);
      chk("rx_ack", rx_ack, rx ? ack_e : '0);
      chk("timeout_err", to_err, err_e);
      chk("cold_ack_idle", cold_ack, 0);
      next_cyc();
    end
    err_prev = err_e;
    tx_rst = '0;
    rx_rst = '0;
    tx_stable = ALL;
    rx_ready = ALL;
  endtask

  initial begin
    int n;
    bit in_rst;
    rst = 1'b1;
    cold_rst = 1'b0;
    tx_rst = '0;
    rx_rst = '0;
    tx_stable = '0;
    rx_ready = '0;
    err_prev = '0;

    // power-up: reset values, then resets drop on the first clock and init waits for ready
    @(posedge clk);
    #1;
    chk("rst_chan_tx", chan_tx_rst, ALL);
    chk("rst_chan_rx", chan_rx_rst, ALL);
    chk("rst_acks", {tx_ack, rx_ack}, 0);
    chk("rst_cold_ack", cold_ack, 0);
    chk("rst_err", to_err, 0);
    rst = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 3; k++) begin
      next_cyc();
      if (cyc == 3) begin
        tx_stable = ALL;
        rx_ready = ALL;
      end
      sample();
      chk("init_chan_tx", chan_tx_rst, 0);
      chk("init_chan_rx", chan_rx_rst, 0);
      chk("init_cold_ack", cold_ack, 0);
    end
    while (cyc < 10) next_cyc();

    // TX ch2: req at 10, ack at 27, drop at 40, ready at 45, ack low at 46
    run_dir(1'b0, 2, 30, 4);
    // short pulse on TX ch7
    run_dir(1'b0, 7, 1, 3);
    // RX ch0 times out
    run_dir(1'b1, 0, 20, TIMEOUT_CYC + 6);
    chk("err_sticky", to_err[0], 1);

    for (int i = 0; i < 10; i++)
      run_dir(1'($urandom_range(0, 1)), $urandom_range(0, NUM_CH - 1),
              $urandom_range(1, 40), $urandom_range(0, TIMEOUT_CYC + 4));

    // cold and RX ch5 together: cold wins, errors cleared
    n = cyc;
    for (int c = n; c <= n + 30; c++) begin
      cold_rst = (c < n + 25);
      rx_rst = (c < n + 20) ? 16'h0020 : 16'h0000;
      sample();
      in_rst = (c > n && c <= n + 25);
      chk("cold_chan_tx", chan_tx_rst, in_rst ? ALL : '0);
      chk("cold_chan_rx", chan_rx_rst, in_rst ? ALL : '0);
      chk("cold_ack", cold_ack, (c >= n + 1 + HOLD_CYC && c <= n + 26) ? 1 : 0);
      chk("cold_ch_acks", {tx_ack, rx_ack}, 0);
      chk("cold_err", to_err, (c == n) ? err_prev : '0);
      next_cyc();
    end
    err_prev = '0;
    run_dir(1'b1, 5, 25, 2);

    // async reset while TX ch3 is HELD
    tx_rst = 16'h0008;
    repeat (20) next_cyc();
    sample();
    chk("pre_arst_ack", tx_ack, 16'h0008);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_chan_tx", chan_tx_rst, ALL);
    chk("arst_chan_rx", chan_rx_rst, ALL);
    chk("arst_acks", {tx_ack, rx_ack}, 0);
    chk("arst_cold_ack", cold_ack, 0);
    chk("arst_err", to_err, 0);
    tx_rst = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    err_prev = '0;
    next_cyc();
    sample();
    chk("rel_chan_tx", chan_tx_rst, 0);
    chk("rel_chan_rx", chan_rx_rst, 0);
    next_cyc();
    next_cyc();
    run_dir(1'b0, 3, 18, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
